// File: rtl/forwarding_status_pipe_pkg.sv
// Shared types for the register-forwarding producer: entry layout, per-stage status bundle.
package forwarding_status_pipe_pkg;

    localparam int unsigned REG_ADDR_W = 5;
    localparam int unsigned DATA_W     = 32;

    typedef logic [REG_ADDR_W-1:0] reg_addr_t;
    typedef logic [DATA_W-1:0]     reg_data_t;

    typedef struct packed {
        reg_addr_t address;
        reg_data_t data;
        logic      valid;
    } forwarding_entry_t;

    typedef struct packed {
        forwarding_entry_t execute_out;
        forwarding_entry_t access_out;
        forwarding_entry_t writeback_in;
    } forwarding_data_status_t;

    localparam forwarding_entry_t FORWARDING_BUBBLE = '{address: '0, data: '0, valid: 1'b0};

    // A real destination whose data is not final yet (an in-flight load).
    function automatic logic entry_unresolved(forwarding_entry_t e);
        return (e.address != '0) && !e.valid;
    endfunction

endpackage

// File: rtl/forwarding_status_pipe_if.sv
// Pipeline-side signal bundle of the forwarding producer: execute/memory inputs, status and RF write outputs.
interface forwarding_status_pipe_if;
    import forwarding_status_pipe_pkg::*;

    logic                    stall;
    logic                    flush;
    logic                    ex_writes_reg;
    reg_addr_t               ex_rd;
    reg_data_t               ex_data;
    logic                    ex_data_ready;
    logic                    mem_data_ready;
    reg_data_t               mem_data;
    forwarding_data_status_t data_in_pipeline;
    logic                    load_pending;
    logic                    wb_we;
    reg_addr_t               wb_address;
    reg_data_t               wb_data;

    modport master (
        output stall, flush, ex_writes_reg, ex_rd, ex_data, ex_data_ready,
               mem_data_ready, mem_data,
        input  data_in_pipeline, load_pending, wb_we, wb_address, wb_data
    );

    modport slave (
        input  stall, flush, ex_writes_reg, ex_rd, ex_data, ex_data_ready,
               mem_data_ready, mem_data,
        output data_in_pipeline, load_pending, wb_we, wb_address, wb_data
    );

endinterface

// File: rtl/forwarding_status_pipe_stage_reg.sv
// One pipeline slot of forwarding state with clear/load/hold and late-load fill.
module forwarding_stage_reg
    import forwarding_status_pipe_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear_i,
    input  logic              load_i,
    input  forwarding_entry_t entry_i,
    input  logic              fill_en_i,
    input  reg_data_t         fill_data_i,
    output forwarding_entry_t entry_o
);

    forwarding_entry_t slot_q, slot_d;
    forwarding_entry_t filled;
    logic              fill_hit;

    // Fill only resolves an entry already resident; bubbles (address 0) are never filled.
    always_comb begin
        filled       = slot_q;
        filled.data  = fill_data_i;
        filled.valid = 1'b1;
        fill_hit     = fill_en_i && entry_unresolved(slot_q);
    end

    // Next slot contents: clear beats load, load beats fill, otherwise hold.
    always_comb begin
        slot_d = slot_q;
        if (clear_i) begin
            slot_d = FORWARDING_BUBBLE;
        end else if (load_i) begin
            slot_d = entry_i;
        end else if (fill_hit) begin
            slot_d = filled;
        end
    end

    // Slot register with synchronous active-low reset to a bubble.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            slot_q <= FORWARDING_BUBBLE;
        end else begin
            slot_q <= slot_d;
        end
    end

    // Arriving load data is visible in the same cycle it is presented.
    assign entry_o = fill_hit ? filled : slot_q;

endmodule

// File: rtl/forwarding_status_pipe.sv
// Forwarding status producer: tracks rd writes through EX/MEM and MEM/WB and drives the RF write port.
module forwarding_status_pipe
    import forwarding_status_pipe_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst_n,
    forwarding_status_pipe_if.slave  bus
);

    forwarding_entry_t execute_out;
    forwarding_entry_t access_out;
    forwarding_entry_t writeback_in;

    // Execute-stage entry; flushed, non-writing or x0 instructions publish a bubble.
    always_comb begin
        execute_out = FORWARDING_BUBBLE;
        if (bus.ex_writes_reg && !bus.flush && (bus.ex_rd != '0)) begin
            execute_out = '{address: bus.ex_rd, data: bus.ex_data, valid: bus.ex_data_ready};
        end
    end

    forwarding_stage_reg u_access (
        .clk         (clk),
        .rst_n       (rst_n),
        .clear_i     (bus.flush),
        .load_i      (!bus.stall),
        .entry_i     (execute_out),
        .fill_en_i   (bus.mem_data_ready),
        .fill_data_i (bus.mem_data),
        .entry_o     (access_out)
    );

    forwarding_stage_reg u_writeback (
        .clk         (clk),
        .rst_n       (rst_n),
        .clear_i     (1'b0),
        .load_i      (!bus.stall),
        .entry_i     (access_out),
        .fill_en_i   (1'b0),
        .fill_data_i ('0),
        .entry_o     (writeback_in)
    );

    // access_out already folds in this cycle's fill, so "still unresolved" is exactly "pending".
    assign bus.load_pending     = entry_unresolved(access_out);
    assign bus.data_in_pipeline = '{execute_out: execute_out, access_out: access_out,
                                    writeback_in: writeback_in};
    assign bus.wb_we            = (writeback_in.address != '0) && writeback_in.valid;
    assign bus.wb_address       = writeback_in.address;
    assign bus.wb_data          = writeback_in.data;

    // An unresolved load must never reach writeback; the hazard unit has to stall instead.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            assert (!entry_unresolved(writeback_in));
        end
    end

endmodule

// File: tb/tb_forwarding_status_pipe.sv
// Directed bench for forwarding_status_pipe with a writeback scoreboard.
module tb_forwarding_status_pipe;
    import forwarding_status_pipe_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    int   total = 0;
    int   bad   = 0;

    typedef struct packed {
        logic [4:0]  a;
        logic [31:0] d;
    } wr_t;
    wr_t exp_q[$];

    forwarding_status_pipe_if fp_if ();

    forwarding_status_pipe dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (fp_if)
    );

    always #5 clk = ~clk;

    function automatic forwarding_entry_t ent(logic [4:0] a, logic [31:0] d, logic v);
        ent = '{address: a, data: d, valid: v};
    endfunction

    task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        fp_if.stall          = 1'b0;
        fp_if.flush          = 1'b0;
        fp_if.ex_writes_reg  = 1'b0;
        fp_if.ex_rd          = '0;
        fp_if.ex_data        = '0;
        fp_if.ex_data_ready  = 1'b0;
        fp_if.mem_data_ready = 1'b0;
        fp_if.mem_data       = '0;
    endtask

    task automatic issue(logic [4:0] rd, logic [31:0] d, logic rdy);
        fp_if.ex_writes_reg = 1'b1;
        fp_if.ex_rd         = rd;
        fp_if.ex_data       = d;
        fp_if.ex_data_ready = rdy;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: a write retires on the last cycle it sits in writeback.
    always @(negedge clk) begin
        if (fp_if.wb_we === 1'b1 && (fp_if.stall === 1'b0 || rst_n === 1'b0)) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $error("FAIL wb_unexpected observed=%0d/%h expected=none",
                       fp_if.wb_address, fp_if.wb_data);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                assert ({fp_if.wb_address, fp_if.wb_data} === {e.a, e.d}) else begin
                    bad++;
                    $error("FAIL wb_order observed=%0d/%h expected=%0d/%h",
                           fp_if.wb_address, fp_if.wb_data, e.a, e.d);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        idle_inputs();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Reset state
        @(negedge clk);
        chk("rst_access", 64'(fp_if.data_in_pipeline.access_out), 64'(FORWARDING_BUBBLE));
        chk("rst_wb", 64'(fp_if.data_in_pipeline.writeback_in), 64'(FORWARDING_BUBBLE));
        chk("rst_we", 64'(fp_if.wb_we), 64'd0);
        chk("rst_lp", 64'(fp_if.load_pending), 64'd0);

        // ALU write x5 = 0x1234
        next_cycle();
        issue(5'd5, 32'h1234, 1'b1);
        exp_q.push_back('{a: 5'd5, d: 32'h1234});
        @(negedge clk);
        chk("alu_ex", 64'(fp_if.data_in_pipeline.execute_out), 64'(ent(5'd5, 32'h1234, 1'b1)));
        next_cycle();
        idle_inputs();
        @(negedge clk);
        chk("alu_acc", 64'(fp_if.data_in_pipeline.access_out), 64'(ent(5'd5, 32'h1234, 1'b1)));
        next_cycle();
        @(negedge clk);
        chk("alu_we", 64'(fp_if.wb_we), 64'd1);
        chk("alu_wb", {27'd0, fp_if.wb_address, fp_if.wb_data}, {27'd0, 5'd5, 32'h1234});

        // Load x7, stalled until data arrives on the third stalled cycle
        next_cycle();
        issue(5'd7, 32'h55, 1'b0);
        exp_q.push_back('{a: 5'd7, d: 32'hDEADBEEF});
        @(negedge clk);
        chk("ld_ex", 64'(fp_if.data_in_pipeline.execute_out), 64'(ent(5'd7, 32'h55, 1'b0)));
        next_cycle();
        idle_inputs();
        fp_if.stall = 1'b1;
        @(negedge clk);
        chk("ld_lp1", 64'(fp_if.load_pending), 64'd1);
        chk("ld_acc1", 64'(fp_if.data_in_pipeline.access_out), 64'(ent(5'd7, 32'h55, 1'b0)));
        next_cycle();
        @(negedge clk);
        chk("ld_lp2", 64'(fp_if.load_pending), 64'd1);
        next_cycle();
        fp_if.mem_data_ready = 1'b1;
        fp_if.mem_data       = 32'hDEADBEEF;
        @(negedge clk);
        chk("ld_fill_acc", 64'(fp_if.data_in_pipeline.access_out), 64'(ent(5'd7, 32'hDEADBEEF, 1'b1)));
        chk("ld_fill_lp", 64'(fp_if.load_pending), 64'd0);
        chk("ld_wb_held", 64'(fp_if.wb_we), 64'd0);
        next_cycle();
        idle_inputs();
        @(negedge clk);
        chk("ld_acc_reg", 64'(fp_if.data_in_pipeline.access_out), 64'(ent(5'd7, 32'hDEADBEEF, 1'b1)));
        next_cycle();
        @(negedge clk);
        chk("ld_wb", {27'd0, fp_if.wb_address, fp_if.wb_data}, {27'd0, 5'd7, 32'hDEADBEEF});

        // Flush alone
        next_cycle();
        issue(5'd9, 32'h99, 1'b1);
        fp_if.flush = 1'b1;
        @(negedge clk);
        chk("fl_ex", 64'(fp_if.data_in_pipeline.execute_out), 64'(FORWARDING_BUBBLE));
        next_cycle();
        idle_inputs();
        @(negedge clk);
        chk("fl_acc", 64'(fp_if.data_in_pipeline.access_out), 64'(FORWARDING_BUBBLE));

        // Flush + stall: access cleared, writeback held
        next_cycle();
        issue(5'd11, 32'hB, 1'b1);
        exp_q.push_back('{a: 5'd11, d: 32'hB});
        next_cycle();
        issue(5'd12, 32'hC, 1'b1);
        next_cycle();
        issue(5'd9, 32'h99, 1'b1);
        fp_if.flush = 1'b1;
        fp_if.stall = 1'b1;
        @(negedge clk);
        chk("fs_ex", 64'(fp_if.data_in_pipeline.execute_out), 64'(FORWARDING_BUBBLE));
        chk("fs_acc_pre", 64'(fp_if.data_in_pipeline.access_out), 64'(ent(5'd12, 32'hC, 1'b1)));
        next_cycle();
        idle_inputs();
        @(negedge clk);
        chk("fs_acc", 64'(fp_if.data_in_pipeline.access_out), 64'(FORWARDING_BUBBLE));
        chk("fs_wb_hold", 64'(fp_if.data_in_pipeline.writeback_in), 64'(ent(5'd11, 32'hB, 1'b1)));

        // Write to x0
        next_cycle();
        issue(5'd0, 32'h77, 1'b1);
        @(negedge clk);
        chk("x0_ex", 64'(fp_if.data_in_pipeline.execute_out.address), 64'd0);
        next_cycle();
        idle_inputs();
        @(negedge clk);
        chk("x0_acc", 64'(fp_if.data_in_pipeline.access_out.address), 64'd0);
        next_cycle();
        @(negedge clk);
        chk("x0_wb", 64'(fp_if.data_in_pipeline.writeback_in.address), 64'd0);
        chk("x0_we", 64'(fp_if.wb_we), 64'd0);

        // Back-to-back x3 = 1, 2, 3
        for (int unsigned i = 1; i <= 3; i++) begin
            next_cycle();
            issue(5'd3, 32'(i), 1'b1);
            exp_q.push_back('{a: 5'd3, d: 32'(i)});
        end
        @(negedge clk);
        chk("b2b_ex", 64'(fp_if.data_in_pipeline.execute_out), 64'(ent(5'd3, 32'd3, 1'b1)));
        chk("b2b_acc", 64'(fp_if.data_in_pipeline.access_out), 64'(ent(5'd3, 32'd2, 1'b1)));
        chk("b2b_wb", 64'(fp_if.data_in_pipeline.writeback_in), 64'(ent(5'd3, 32'd1, 1'b1)));
        next_cycle();
        idle_inputs();
        repeat (3) next_cycle();

        // Reset while a load is pending, then late load data
        issue(5'd8, 32'h0, 1'b0);
        next_cycle();
        idle_inputs();
        fp_if.stall = 1'b1;
        @(negedge clk);
        chk("rl_lp", 64'(fp_if.load_pending), 64'd1);
        rst_n = 1'b0;
        next_cycle();
        rst_n = 1'b1;
        fp_if.stall          = 1'b0;
        fp_if.mem_data_ready = 1'b1;
        fp_if.mem_data       = 32'hBAD0BAD0;
        @(negedge clk);
        chk("rl_acc", 64'(fp_if.data_in_pipeline.access_out), 64'(FORWARDING_BUBBLE));
        chk("rl_wb", 64'(fp_if.data_in_pipeline.writeback_in), 64'(FORWARDING_BUBBLE));
        chk("rl_lp0", 64'(fp_if.load_pending), 64'd0);
        next_cycle();
        idle_inputs();
        @(negedge clk);
        chk("rl_we", 64'(fp_if.wb_we), 64'd0);
        chk("rl_wb2", 64'(fp_if.data_in_pipeline.writeback_in), 64'(FORWARDING_BUBBLE));

        repeat (3) next_cycle();
        chk("sb_drain", 64'(exp_q.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/forwarding_status_pipe.md
# forwarding_status_pipe

Producer side of the register-forwarding interface. It tracks every in-flight destination-register write from the execute stage through memory access to writeback. It publishes the per-stage `forwarding_data_status_t` consumed by each operand forwarder, and drives the register-file write port. It sits alongside the EX/MEM and MEM/WB pipeline registers and owns the address/data/valid portion of them.

## Interface
Parameters:
- none; widths come from `cpu_types` (5-bit register address, 32-bit data).

Ports:
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst_n`  in  1  synchronous, active-low reset.
- `stall`  in  1  hold EX/MEM and MEM/WB slots (from hazard unit).
- `flush`  in  1  discard the instruction leaving execute.
- `ex_writes_reg`  in  1  execute-stage instruction writes rd.
- `ex_rd`  in  5  destination register of execute-stage instruction.
- `ex_data`  in  32  ALU result.
- `ex_data_ready`  in  1  `ex_data` is final; 0 for loads.
- `mem_data_ready`  in  1  load result available this cycle.
- `mem_data`  in  32  load result.
- `data_in_pipeline`  out  `forwarding_data_status_t`  `execute_out` / `access_out` / `writeback_in` entries, each {address, data, valid}.
- `load_pending`  out  1  access slot holds an unresolved load.
- `wb_we`  out  1  register-file write enable.
- `wb_address`  out  5  register-file write address.
- `wb_data`  out  32  register-file write data.

## Operation
- Entry encoding: address 0 means "no write"; consumers ignore address 0, so a bubble is {0, 0, 0}.
- `execute_out` (combinational):
  - {ex_rd, ex_data, ex_data_ready} when `ex_writes_reg && !flush && ex_rd != 0`;
  - otherwise a bubble.
- Access slot (EX/MEM):
  - Precedence 1: `flush=1` loads a bubble, regardless of `stall`.
  - Precedence 2: else `stall=0` loads the `execute_out` value.
  - Precedence 3: else the slot holds.
  - Load fill: if the slot holds (or is loaded with) an entry with valid=0 and `mem_data_ready=1`, in the same cycle that entry's data becomes `mem_data` and valid becomes 1. This applies during stall too.
  - When loading from `execute_out` with `mem_data_ready=1`, the fill does not apply to the incoming entry; it applies only to an entry already resident.
- `access_out`:
  - Equals the access slot, except a resident unresolved load with `mem_data_ready=1` is shown as {addr, mem_data, 1} combinationally.
- Writeback slot (MEM/WB):
  - `stall=0`: loads the `access_out` value.
  - `stall=1`: holds.
  - `writeback_in` equals this slot.
- `load_pending = access slot address != 0 && !valid && !mem_data_ready`. The hazard unit must keep `stall` high while it is set.
- Writeback output: `wb_we = writeback_in.address != 0 && writeback_in.valid`; `wb_address`/`wb_data` come from the slot. Repeated writes while stalled are allowed (idempotent).
- An invalid entry reaching writeback (a protocol violation) suppresses `wb_we`. Simulation asserts on it.

## Timing
- Reset (rst_n=0 at clock edge): both slots become bubbles. Outputs the next cycle: `access_out`=`writeback_in`={0,0,0}, `wb_we`=0, `load_pending`=0.
- `execute_out` follows its inputs with zero latency.
- Instruction latency:
  - visible in `execute_out` in cycle N;
  - in `access_out` in N+1;
  - in `writeback_in`, and written to the register file, in N+2, when unstalled.
- Each stalled cycle adds one cycle of latency per held slot.
- Load data presented at cycle M appears in `access_out` the same cycle, with valid=1, and is registered at edge M.
- A reset asserted mid-operation drops all in-flight entries. Pending loads are forgotten; a late `mem_data_ready` after reset is ignored, because the slot is a bubble.

## Structure
- `cpu_types` gains:
  - `forwarding_entry_t` {address[4:0], data[31:0], valid};
  - `forwarding_data_status_t` {execute_out, access_out, writeback_in};
  - constant `FORWARDING_BUBBLE`.
- One sub-module, `forwarding_stage_reg`: a single slot with load/hold/clear/fill controls. It is instantiated twice; fill is tied off on the writeback instance.

## Test plan
- Reset, then ALU write x5=0x1234 with no stall → `execute_out`={5,0x1234,1} in cycle 0, `access_out` in cycle 1, `wb_we`=1 with x5/0x1234 in cycle 2.
- Load x7 (`ex_data_ready`=0), stall while `load_pending`, `mem_data`=0xDEADBEEF on 3rd stalled cycle → `access_out`.valid rises that cycle, `load_pending` falls, `wb_data`=0xDEADBEEF two cycles after stall release.
- `flush`=1 with ex_rd=9, and `flush`+`stall` together → `execute_out` and next `access_out` are bubbles; the writeback slot still holds under stall.
- `ex_rd`=0 with `ex_writes_reg`=1 → all stages publish address 0; `wb_we` never asserts.
- Back-to-back writes x3=1, x3=2, x3=3 → stages show 3/2/1 simultaneously; writebacks appear in program order.
- `rst_n`=0 while a load is pending, then `mem_data_ready`=1 → all slots are bubbles; no write occurs.
